// File: rtl/mips_immediate_extend_stage_pkg.sv
// Shared encodings and control-word type for the immediate extend stage and its forwarding users.
// Field-select macros IMM_CTRL_EXTEND / IMM_CTRL_SHIFT are defined alongside the package.
`ifndef MIPS_IMMEDIATE_EXTEND_STAGE_PKG_SV
`define MIPS_IMMEDIATE_EXTEND_STAGE_PKG_SV

`define IMM_CTRL_EXTEND(c) c.extend
`define IMM_CTRL_SHIFT(c) c.shift

package mips_immediate_extend_stage_pkg;

  typedef enum logic {
    ExtSigned   = 1'b0,
    ExtUnsigned = 1'b1
  } extend_e;

  typedef enum logic {
    ShiftNone   = 1'b0,
    ShiftLeft16 = 1'b1
  } shift_e;

  typedef struct packed {
    extend_e extend;
    shift_e  shift;
  } imm_ctrl_t;

  localparam int unsigned LEFT16_AMOUNT = 16;

endpackage

`endif

// File: rtl/mips_immediate_extend_stage_if.sv
// Upstream/downstream valid-ready bundle of the immediate extend stage.
// master = the surrounding pipeline, slave = the stage itself.
interface mips_immediate_extend_stage_if #(
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [IMM_WIDTH-1:0]  in_imm;
  logic                  in_extend;
  logic                  in_shift;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, in_imm, in_extend, in_shift, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_extend, in_shift, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );

endinterface

// File: rtl/mips_immediate_extend_compute.sv
// Combinational immediate extend/shift; shared with the operand forwarding logic.
// Left16 ignores the extend mode and truncates to DATA_WIDTH when the immediate is as wide.
module mips_immediate_extend_compute
  import mips_immediate_extend_stage_pkg::*;
#(
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [IMM_WIDTH-1:0]  imm,
  input  imm_ctrl_t             ctrl,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = DATA_WIDTH'(imm);
    if (`IMM_CTRL_SHIFT(ctrl) == ShiftLeft16) begin
      result = DATA_WIDTH'(imm) << LEFT16_AMOUNT;
    end else if (`IMM_CTRL_EXTEND(ctrl) == ExtSigned) begin
      result = DATA_WIDTH'($signed(imm));
    end
  end

endmodule

// File: rtl/mips_immediate_extend_stage.sv
// Decode-to-execute immediate stage: extend/shift, registered behind a 2-entry skid buffer.
// Optional stall counter enabled by MIPS_IMMEDIATE_EXTEND_STAGE_STALL_COUNT_EN.
module mips_immediate_extend_stage
  import mips_immediate_extend_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH  = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  mips_immediate_extend_stage_if.slave       bus
`ifdef MIPS_IMMEDIATE_EXTEND_STAGE_STALL_COUNT_EN
  ,
  output logic [31:0]                        stall_count
`endif
);

  imm_ctrl_t             in_ctrl;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  accept;
  logic                  pop;

  logic                  vm_q, vm_d;
  logic                  vs_q, vs_d;
  logic [DATA_WIDTH-1:0] m_imm_q, m_imm_d;
  logic [TAG_WIDTH-1:0]  m_tag_q, m_tag_d;
  logic [DATA_WIDTH-1:0] s_imm_q, s_imm_d;
  logic [TAG_WIDTH-1:0]  s_tag_q, s_tag_d;

  assign in_ctrl = '{extend: extend_e'(bus.in_extend), shift: shift_e'(bus.in_shift)};

  mips_immediate_extend_compute #(
    .IMM_WIDTH  (IMM_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_compute (
    .imm    (bus.in_imm),
    .ctrl   (in_ctrl),
    .result (in_result)
  );

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign bus.in_ready  = !vs_q;
  assign bus.out_valid = vm_q;
  assign bus.out_imm   = m_imm_q;
  assign bus.out_tag   = m_tag_q;

  assign accept = bus.in_valid && !vs_q;
  assign pop    = vm_q && bus.out_ready;

  always_comb begin
    vm_d    = vm_q;
    vs_d    = vs_q;
    m_imm_d = m_imm_q;
    m_tag_d = m_tag_q;
    s_imm_d = s_imm_q;
    s_tag_d = s_tag_q;
    if (flush) begin
      vm_d = 1'b0;
      vs_d = 1'b0;
    end else if (!vm_q) begin
      if (accept) begin
        vm_d    = 1'b1;
        m_imm_d = in_result;
        m_tag_d = bus.in_tag;
      end
    end else if (pop) begin
      if (vs_q) begin
        m_imm_d = s_imm_q;
        m_tag_d = s_tag_q;
        vs_d    = 1'b0;
      end else if (accept) begin
        m_imm_d = in_result;
        m_tag_d = bus.in_tag;
      end else begin
        vm_d = 1'b0;
      end
    end else if (accept) begin
      vs_d    = 1'b1;
      s_imm_d = in_result;
      s_tag_d = bus.in_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vm_q    <= 1'b0;
      vs_q    <= 1'b0;
      m_imm_q <= '0;
      m_tag_q <= '0;
      s_imm_q <= '0;
      s_tag_q <= '0;
    end else begin
      vm_q    <= vm_d;
      vs_q    <= vs_d;
      m_imm_q <= m_imm_d;
      m_tag_q <= m_tag_d;
      s_imm_q <= s_imm_d;
      s_tag_q <= s_tag_d;
    end
  end

`ifdef MIPS_IMMEDIATE_EXTEND_STAGE_STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (vm_q && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mips_immediate_extend_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_mips_immediate_extend_stage;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tag;
  } ent_t;

  logic clock;
  logic reset;
  logic flush;
  logic [31:0] stall_count;
  logic mon_en;
  int   n_cmp;
  int   n_bad;

  ent_t        q[$];
  logic [31:0] stall_m;

  mips_immediate_extend_stage_if #(
    .IMM_WIDTH  (16),
    .DATA_WIDTH (32),
    .TAG_WIDTH  (32)
  ) bus ();

  mips_immediate_extend_stage #(
    .DATA_WIDTH (32),
    .IMM_WIDTH  (16),
    .TAG_WIDTH  (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus)
`ifdef MIPS_IMMEDIATE_EXTEND_STAGE_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

`ifndef MIPS_IMMEDIATE_EXTEND_STAGE_STALL_COUNT_EN
  assign stall_count = '0;
`endif

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [15:0] imm, input logic ext,
                                          input logic sh);
    int unsigned v;
    v = imm;
    if (sh) return v * 32'd65536;
    if (!ext && v >= 32768) return v + 32'hFFFF_0000;
    return v;
  endfunction

  // Model: FIFO of at most two entries; updated with the inputs the next rising edge will see.
  always @(negedge clock) begin
    if (mon_en) begin
      logic acc;
      logic pp;
      check("out_valid", bus.out_valid, q.size() > 0);
      check("in_ready", bus.in_ready, q.size() < 2);
      if (q.size() > 0) begin
        check("out_imm", bus.out_imm, q[0].imm);
        check("out_tag", bus.out_tag, q[0].tag);
      end
`ifdef MIPS_IMMEDIATE_EXTEND_STAGE_STALL_COUNT_EN
      check("stall_count", stall_count, stall_m);
`endif
      if (reset) begin
        q.delete();
        stall_m = 0;
      end else begin
        if (q.size() > 0 && !bus.out_ready && stall_m != 32'hFFFF_FFFF) stall_m++;
        if (flush) begin
          q.delete();
        end else begin
          acc = bus.in_valid && (q.size() < 2);
          pp  = (q.size() > 0) && bus.out_ready;
          if (pp) void'(q.pop_front());
          if (acc) q.push_back('{imm: ref_imm(bus.in_imm, bus.in_extend, bus.in_shift),
                                 tag: bus.in_tag});
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] imm, input logic ext, input logic sh,
                       input logic [31:0] tag);
    bus.in_valid  = 1'b1;
    bus.in_imm    = imm;
    bus.in_extend = ext;
    bus.in_shift  = sh;
    bus.in_tag    = tag;
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    flush = 1'b0;
    mon_en = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    stall_m = 0;
    bus.in_valid = 1'b0;
    bus.in_imm = '0;
    bus.in_extend = 1'b0;
    bus.in_shift = 1'b0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_imm", bus.out_imm, 0);
    check("rst_out_tag", bus.out_tag, 0);

    // Extend/shift cases
    bus.out_ready = 1'b1;
    drive(16'h8001, 1'b0, 1'b0, 32'h1);
    step();
    check("signed_none", bus.out_imm, 32'hFFFF_8001);
    drive(16'h8001, 1'b1, 1'b0, 32'h2);
    step();
    check("unsigned_none", bus.out_imm, 32'h0000_8001);
    drive(16'h1234, 1'b0, 1'b1, 32'h3);
    step();
    check("signed_left16", bus.out_imm, 32'h1234_0000);
    bus.in_valid = 1'b0;
    step();

    // Backpressure
    bus.out_ready = 1'b0;
    drive(16'h000A, 1'b1, 1'b0, 32'hA);
    step();
    drive(16'h000B, 1'b1, 1'b0, 32'hB);
    step();
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_head_a", bus.out_tag, 32'hA);
    drive(16'h000C, 1'b1, 1'b0, 32'hC);
    step();
    bus.out_ready = 1'b1;
    step();
    check("bp_head_b", bus.out_tag, 32'hB);
    step();
    check("bp_head_c", bus.out_tag, 32'hC);
    bus.in_valid = 1'b0;
    step();
    check("bp_drained", bus.out_valid, 0);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(16'($urandom), 1'($urandom), 1'($urandom), 32'(i));
      step();
      check("stream_tag", bus.out_tag, 32'(i));
      check("stream_in_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    step();

    // Flush with both registers full and an offered entry
    bus.out_ready = 1'b0;
    drive(16'h0100, 1'b0, 1'b0, 32'h100);
    step();
    drive(16'h0101, 1'b0, 1'b0, 32'h101);
    step();
    check("fl_full", bus.in_ready, 0);
    flush = 1'b1;
    drive(16'h0102, 1'b0, 1'b0, 32'h102);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    step();
    step();
    check("fl_no_ghost", bus.out_valid, 0);

    // Reset while holding two entries, then a fresh 5-cycle stall
    bus.out_ready = 1'b0;
    drive(16'h0200, 1'b0, 1'b0, 32'h200);
    step();
    drive(16'h0201, 1'b0, 1'b0, 32'h201);
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rr_out_valid", bus.out_valid, 0);
    check("rr_out_imm", bus.out_imm, 0);
    check("rr_in_ready", bus.in_ready, 1);
`ifdef MIPS_IMMEDIATE_EXTEND_STAGE_STALL_COUNT_EN
    check("rr_stall_zero", stall_count, 0);
`endif
    drive(16'h0300, 1'b0, 1'b0, 32'h300);
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
`ifdef MIPS_IMMEDIATE_EXTEND_STAGE_STALL_COUNT_EN
    check("stall_five", stall_count, 5);
`endif
    bus.out_ready = 1'b1;
    step();

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_imm    = 16'($urandom);
      bus.in_extend = 1'($urandom);
      bus.in_shift  = 1'($urandom);
      bus.in_tag    = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 29) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      step();
    end
    flush = 1'b0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
